// File: rtl/lc3b_types_pkg.sv
// rtl/lc3b_types_pkg.sv - LC-3b shared types plus write-back request and arbitration encodings
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_nzp;

  localparam lc3b_nzp NZP_N = 3'b100;
  localparam lc3b_nzp NZP_Z = 3'b010;
  localparam lc3b_nzp NZP_P = 3'b001;

  typedef struct packed {
    logic     load_reg;
    logic     ld_cc;
    lc3b_reg  dest;
    lc3b_word data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO,
    GNT_MDU
  } wb_grant_e;

  function automatic lc3b_nzp gen_cc(input lc3b_word d);
    if (d[15])          return NZP_N;
    else if (d == 16'h0) return NZP_Z;
    else                return NZP_P;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// rtl/wb_port_arbiter_fifo.sv - synchronous FIFO of write-back requests for queued MDU results
// probe_hit flags a queued regfile write to probe_dest, used for the WAW check in the parent.
module wb_result_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  input  lc3b_reg                probe_dest,
  output logic                   probe_hit
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem_q [DEPTH];
  wb_req_t        mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  off_v;
  logic           push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    probe_hit = 1'b0;
    off_v     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v = AW'(i) - rd_ptr_q;
      if (({1'b0, off_v} < count_q) && mem_q[i].load_reg && (mem_q[i].dest == probe_dest))
        probe_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the regfile write port and CC load between write-back and the MDU
// Define WB_MDU_BYPASS_EN to let an MDU result skip the empty FIFO when the port is idle.
module wb_port_arbiter
  import lc3b_types::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wb_valid,
  input  logic                        wb_load_reg,
  input  logic                        wb_ld_cc,
  input  logic [2:0]                  wb_dest,
  input  logic [15:0]                 wb_data,
  output logic                        stall_wb,
  input  logic                        mdu_valid,
  output logic                        mdu_ready,
  input  logic [2:0]                  mdu_dest,
  input  logic [15:0]                 mdu_data,
  input  logic                        mdu_ld_cc,
  output logic                        ld_regfile,
  output logic [2:0]                  dest_reg,
  output logic [15:0]                 reg_data,
  output logic                        ld_cc,
  output logic [2:0]                  gencc_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic       pipe_req, fifo_req, fifo_full, fifo_empty, fifo_hit;
  logic       forced, bypass, push, pop;
  wb_req_t    pipe_entry, mdu_entry, fifo_head, win;
  wb_grant_e  grant;

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          ld_regfile_q, ld_regfile_d;
  logic          ld_cc_q, ld_cc_d;
  lc3b_reg       dest_q, dest_d;
  lc3b_word      data_q, data_d;
  lc3b_nzp       gencc_q, gencc_d;

  assign pipe_req   = wb_valid & (wb_load_reg | wb_ld_cc);
  assign fifo_req   = ~fifo_empty;
  assign forced     = fifo_req & (wait_cnt_q == WW'(STARVE_LIMIT));
  assign pipe_entry = '{load_reg: wb_load_reg, ld_cc: wb_ld_cc, dest: wb_dest, data: wb_data};
  assign mdu_entry  = '{load_reg: 1'b1, ld_cc: mdu_ld_cc, dest: mdu_dest, data: mdu_data};

`ifdef WB_MDU_BYPASS_EN
  assign bypass = fifo_empty & ~pipe_req & mdu_valid;
`else
  assign bypass = 1'b0;
`endif

  // Readiness looks only at the current count, so a full FIFO refuses even on a same-cycle pop.
  assign mdu_ready = ~fifo_full;
  assign push      = mdu_valid & mdu_ready & ~bypass;
  assign pop       = (grant == GNT_FIFO);
  assign stall_wb  = forced & pipe_req;

  always_comb begin
    grant = GNT_NONE;
    if (forced)        grant = GNT_FIFO;
    else if (pipe_req) grant = GNT_PIPE;
    else if (fifo_req) grant = GNT_FIFO;
    else if (bypass)   grant = GNT_MDU;
  end

  always_comb begin
    win = '0;
    case (grant)
      GNT_PIPE: win = pipe_entry;
      GNT_FIFO: win = fifo_head;
      GNT_MDU:  win = mdu_entry;
      default:  win = '0;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (pop || fifo_empty)
      wait_cnt_d = '0;
    else if (wait_cnt_q != WW'(STARVE_LIMIT))
      wait_cnt_d = wait_cnt_q + WW'(1);
  end

  always_comb begin
    ld_regfile_d = win.load_reg;
    ld_cc_d      = win.ld_cc;
    dest_d       = dest_q;
    data_d       = data_q;
    gencc_d      = gencc_q;
    if (grant != GNT_NONE) begin
      dest_d = win.dest;
      data_d = win.data;
      if (win.ld_cc) gencc_d = gen_cc(win.data);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q   <= '0;
      ld_regfile_q <= 1'b0;
      ld_cc_q      <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      gencc_q      <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ld_regfile_q <= ld_regfile_d;
      ld_cc_q      <= ld_cc_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      gencc_q      <= gencc_d;
    end
  end

  assign ld_regfile = ld_regfile_q;
  assign ld_cc      = ld_cc_q;
  assign dest_reg   = dest_q;
  assign reg_data   = data_q;
  assign gencc_out  = gencc_q;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (mdu_entry),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .probe_dest (wb_dest),
    .probe_hit  (fifo_hit)
  );

  // Issue logic must never let a pipeline write race a queued MDU write to the same register.
  a_no_waw: assert property (@(posedge clk) disable iff (!reset_n)
    !(pipe_req && wb_load_reg && fifo_hit));

endmodule
